// File: rtl/my_sram.sv
// my_sram: small synchronous FIFO on a register-array memory.
// Words leave in arrival order through a registered output port; a write
// offered while full with no simultaneous read is dropped and flagged for
// one cycle on overflow.
module my_sram #(
  parameter int BITS       = 12,
  parameter int WORD_DEPTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            read,
  input  logic            write,
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] data_out,
  output logic            ready,
  output logic            overflow
);

  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(WORD_DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [BITS-1:0]       mem_q [WORD_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [BITS-1:0]       data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // A full FIFO still accepts a write when a read frees the oldest slot in
  // the same edge; an empty FIFO never bypasses the input to the output.
  assign pop  = read && !empty;
  assign push = write && (!full || read);

  // Next-state for pointers, occupancy, output word and drop flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    overflow_d = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_ONE;
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    if (write && full && !read) begin
      overflow_d = 1'b1;
    end
  end

  // Control state register; reset discards all stored words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents survive reset since the pointers make them stale.
  // When full with read+write, wr_ptr equals rd_ptr: the pop above samples
  // the old word before this write lands.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out = data_out_q;
  assign overflow = overflow_q;
  assign ready    = !empty;

endmodule

// File: tb/tb_my_sram.sv
// Directed bench for my_sram: fill, concurrent push/pop, overflow drops,
// full read+write, drain across the pointer wrap, empty-FIFO corner cases
// and asynchronous reset mid-operation.
module tb_my_sram;

  localparam int BITS = 12;

  logic            clk;
  logic            rst_n;
  logic            read;
  logic            write;
  logic [BITS-1:0] data_in;
  logic [BITS-1:0] data_out;
  logic            ready;
  logic            overflow;

  int vectors;
  int miscompares;

  my_sram #(.BITS(12), .WORD_DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .read     (read),
    .write    (write),
    .data_in  (data_in),
    .data_out (data_out),
    .ready    (ready),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rd, input logic wr, input logic [BITS-1:0] din);
    read    = rd;
    write   = wr;
    data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BITS-1:0] exp_do,
                       input logic exp_rdy, input logic exp_ovf);
    vectors++;
    assert (data_out === exp_do) else begin
      miscompares++;
      $error("FAIL %s data_out: observed %03h expected %03h", tag, data_out, exp_do);
    end
    vectors++;
    assert (ready === exp_rdy) else begin
      miscompares++;
      $error("FAIL %s ready: observed %b expected %b", tag, ready, exp_rdy);
    end
    vectors++;
    assert (overflow === exp_ovf) else begin
      miscompares++;
      $error("FAIL %s overflow: observed %b expected %b", tag, overflow, exp_ovf);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    read    = 1'b0;
    write   = 1'b0;
    data_in = '0;
    rst_n   = 1'b0;

    // 1: reset, then idle edges
    #12;
    check("reset", 12'h000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 12'h000);
    step(1'b0, 1'b0, 12'h000);
    check("idle", 12'h000, 1'b0, 1'b0);

    // 2: fill with five words
    step(1'b0, 1'b1, 12'h0E0);
    check("fill0", 12'h000, 1'b1, 1'b0);
    step(1'b0, 1'b1, 12'h0E1);
    step(1'b0, 1'b1, 12'h0E2);
    step(1'b0, 1'b1, 12'h0E3);
    step(1'b0, 1'b1, 12'h0E4);
    check("fill4", 12'h000, 1'b1, 1'b0);

    // 3: concurrent push/pop
    step(1'b1, 1'b1, 12'h0E5);
    check("rw0", 12'h0E0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 12'h0E6);
    check("rw1", 12'h0E1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 12'h0E7);
    check("rw2", 12'h0E2, 1'b1, 1'b0);

    // 4: fill to 8, then dropped writes
    step(1'b0, 1'b1, 12'h0E8);
    step(1'b0, 1'b1, 12'h0E9);
    step(1'b0, 1'b1, 12'h0EA);
    check("full", 12'h0E2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 12'h0EB);
    check("drop_eb", 12'h0E2, 1'b1, 1'b1);
    step(1'b0, 1'b1, 12'h0EC);
    step(1'b0, 1'b1, 12'h0ED);
    step(1'b0, 1'b1, 12'h0EE);
    step(1'b0, 1'b1, 12'h0EF);
    check("drop_ef", 12'h0E2, 1'b1, 1'b1);

    // 5: full with read+write, then another drop
    step(1'b1, 1'b1, 12'h0F0);
    check("full_rw0", 12'h0E3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 12'h0F1);
    check("full_rw1", 12'h0E4, 1'b1, 1'b0);
    step(1'b0, 1'b1, 12'h0F2);
    check("drop_f2", 12'h0E4, 1'b1, 1'b1);
    step(1'b0, 1'b0, 12'h000);
    check("ovf_clear", 12'h0E4, 1'b1, 1'b0);

    // 6: drain across the wrap
    step(1'b1, 1'b1, 12'h0F3);
    check("drain_e5", 12'h0E5, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_e6", 12'h0E6, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_e7", 12'h0E7, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_e8", 12'h0E8, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_e9", 12'h0E9, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_ea", 12'h0EA, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_f0", 12'h0F0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_f1", 12'h0F1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("drain_f3", 12'h0F3, 1'b0, 1'b0);
    step(1'b1, 1'b0, 12'h000); check("empty_rd", 12'h0F3, 1'b0, 1'b0);

    // empty with read+write: push only, no bypass
    step(1'b1, 1'b1, 12'h0AA);
    check("empty_rw", 12'h0F3, 1'b1, 1'b0);
    step(1'b1, 1'b0, 12'h000);
    check("pop_aa", 12'h0AA, 1'b0, 1'b0);

    // asynchronous reset mid-operation
    step(1'b0, 1'b1, 12'h111);
    step(1'b0, 1'b1, 12'h222);
    step(1'b1, 1'b0, 12'h000);
    check("pre_rst", 12'h111, 1'b1, 1'b0);
    read  = 1'b0;
    write = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 12'h000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 12'h000);
    check("rst_discard", 12'h000, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/my_sram.md
Name: my_sram

Overview:
- Synchronous single-clock FIFO buffer built on a WORD_DEPTH x BITS register-array SRAM.
- Words are written in order and read back in first-in-first-out order through a registered output.
- Provides a data-available flag (ready) and a dropped-write error flag (overflow).
- Sits between a streaming producer and consumer as a small elastic buffer.

Parameters:
- BITS, 12, data word width in bits.
- WORD_DEPTH, 8, number of storage words; must equal 2**ADDR_WIDTH.
- ADDR_WIDTH, 3, width of the read and write pointers.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- read  input  1  pop request, sampled each rising edge.
- write  input  1  push request, sampled each rising edge.
- data_in  input  BITS  word to push.
- data_out  output  BITS  registered word from the most recent successful pop.
- ready  output  1  high when the FIFO holds at least one word (count != 0).
- overflow  output  1  registered; high for the cycle after a write was dropped because the FIFO was full.

Behaviour:
- Internal state:
  - wr_ptr and rd_ptr, each ADDR_WIDTH bits, wrapping modulo WORD_DEPTH.
  - count, ADDR_WIDTH+1 bits, range 0..WORD_DEPTH.
  - mem[WORD_DEPTH], each BITS wide.
- full = (count == WORD_DEPTH); empty = (count == 0).
- Reset (rst_n low, asynchronous, takes effect immediately):
  - wr_ptr=0, rd_ptr=0, count=0.
  - data_out=0, overflow=0, ready=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored words.
- Push accepted when write=1 and (not full, or full with read=1): mem[wr_ptr] <= data_in, wr_ptr increments.
- Pop accepted when read=1 and not empty: data_out <= mem[rd_ptr], rd_ptr increments. Latency: the word appears on data_out one clock after the edge that pops it.
- count: +1 on push only, -1 on pop only, unchanged when both or neither occur.
- Write when full with read=0: write dropped, no state change except overflow<=1 at that edge.
- overflow is 0 at every edge without a dropped write, so it is not sticky.
- Read when empty: ignored. data_out holds, pointers unchanged. No error flag.
- Simultaneous read and write:
  - Empty: push only; no bypass, data_out holds, count becomes 1.
  - Full: both occur; the oldest word is popped and the new word is stored; count stays WORD_DEPTH.
  - Otherwise: both occur; count unchanged.
- Pointer wrap from WORD_DEPTH-1 to 0 is seamless.
- data_out holds its value whenever no pop occurs.
- ready is combinational from count (or registered equivalently); it must reflect the count after each edge.

Test Plan:
1. Reset then idle: rst_n=0 -> data_out=0, ready=0, overflow=0. Release with no requests -> all outputs unchanged.
2. Fill with write=1 for 5 edges with data 0x0E0..0x0E4 -> ready=1 after the first edge, count=5, data_out still 0.
3. Concurrent push/pop: continue writing 0x0E5..0x0E7 with read=1 for 3 edges -> data_out steps 0x0E0, 0x0E1, 0x0E2 one cycle after each edge; count stays 5.
4. Overflow: read=0, keep writing 0x0E8..0x0EF -> full after 0x0EA. Writes 0x0EB..0x0EF are dropped, with overflow=1 following each dropped edge.
5. Full with read+write: write 0x0F0 and 0x0F1 with read=1 -> data_out 0x0E3 then 0x0E4, overflow=0, count stays 8. Then write 0x0F2 with read=0 -> dropped, overflow=1.
6. Drain and wrap:
   - Write 0x0F3 with read=1 -> data_out=0x0E5.
   - Then read-only edges -> data_out 0x0E6, 0x0E7, 0x0E8, 0x0E9, 0x0EA, 0x0F0, 0x0F1, 0x0F3.
   - ready drops to 0 after the last word; further reads leave data_out=0x0F3.
   - Assert rst_n=0 mid-sequence -> all outputs return to 0 immediately.
